bk_addsub_pipe: RTL



---
 rtl/bk_addsub_pipe_if.sv | 31 +++
 rtl/bk_addsub_pipe.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bk_addsub_pipe_if.sv
// Stream bundle for bk_addsub_pipe: operand beat in, result beat out, valid/ready on both sides.
// master = producer/consumer side, slave = the arithmetic unit.
interface bk_addsub_pipe_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/bk_addsub_pipe.sv
// Three-stage pipelined add/subtract on a Brent-Kung prefix carry network with valid/ready flow.
// Define BK_ADDSUB_SAT_EN to clamp overflowing results to the signed extreme of operand A's sign.
module bk_addsub_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bk_addsub_pipe_if.slave    bus_io
);
  localparam int Levels = $clog2(WIDTH);
  localparam int W      = int'(WIDTH);

  // Stall chain: a stage moves when it is empty or its successor moves.
  logic adv1, adv2, adv3;

  // Stage 1 state
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_g_q, s1_p_q;
  logic             s1_c0_q, s1_a_msb_q, s1_b_msb_q;
  logic [TAG_W-1:0] s1_tag_q;

  // Stage 2 state
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_gg_q, s2_pg_q, s2_p_q;
  logic             s2_c0_q, s2_a_msb_q, s2_b_msb_q;
  logic [TAG_W-1:0] s2_tag_q;

  // Stage 3 (output) state
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q, out_ovf_q;
  logic [TAG_W-1:0] out_tag_q;

  // Next-state values
  logic [WIDTH-1:0] s1_bx_d, s1_g_d, s1_p_d;
  logic             s1_c0_d;
  logic [WIDTH-1:0] s2_gg_d, s2_pg_d;
  logic [WIDTH-1:0] dn_g;
  logic [WIDTH-1:0] carry, raw_sum;
  logic [WIDTH-1:0] out_sum_d;
  logic             out_cout_d, out_ovf_d;

  assign adv3 = !out_valid_q || bus_io.out_ready;
  assign adv2 = !s2_valid_q || adv3;
  assign adv1 = !s1_valid_q || adv2;

  assign bus_io.in_ready  = adv1;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_sum   = out_sum_q;
  assign bus_io.out_cout  = out_cout_q;
  assign bus_io.out_ovf   = out_ovf_q;
  assign bus_io.out_tag   = out_tag_q;

  // Subtraction is A + ~B + ~cin, so invert B and the carry-in up front.
  always_comb begin
    s1_bx_d = bus_io.in_sub ? ~bus_io.in_b : bus_io.in_b;
    s1_g_d  = bus_io.in_a & s1_bx_d;
    s1_p_d  = bus_io.in_a ^ s1_bx_d;
    s1_c0_d = bus_io.in_cin ^ bus_io.in_sub;
  end

  // Up-sweep. The carry-in is folded into bit 0 so every group G is a carry out of [i:0].
  always_comb begin
    s2_gg_d    = s1_g_q;
    s2_pg_d    = s1_p_q;
    s2_gg_d[0] = s1_g_q[0] | (s1_p_q[0] & s1_c0_q);
    for (int l = 0; l < Levels; l++) begin
      for (int i = 0; i < W; i++) begin
        if (((i + 1) % (2 ** (l + 1))) == 0) begin
          s2_gg_d[i] = s2_gg_d[i] | (s2_pg_d[i] & s2_gg_d[i - 2 ** l]);
          s2_pg_d[i] = s2_pg_d[i] & s2_pg_d[i - 2 ** l];
        end
      end
    end
  end

  // Down-sweep fills in the prefixes the up-sweep left partial.
  always_comb begin
    dn_g = s2_gg_q;
    for (int l = Levels - 2; l >= 0; l--) begin
      for (int i = 0; i < W; i++) begin
        if ((i + 1 >= 3 * 2 ** l) && (((i + 1 - 2 ** l) % (2 ** (l + 1))) == 0)) begin
          dn_g[i] = dn_g[i] | (s2_pg_q[i] & dn_g[i - 2 ** l]);
        end
      end
    end
  end

  always_comb begin
    carry      = {dn_g[WIDTH-2:0], s2_c0_q};
    raw_sum    = s2_p_q ^ carry;
    out_cout_d = dn_g[WIDTH-1];
    out_ovf_d  = (s2_a_msb_q == s2_b_msb_q) && (raw_sum[WIDTH-1] != s2_a_msb_q);
`ifdef BK_ADDSUB_SAT_EN
    if (out_ovf_d) begin
      out_sum_d = s2_a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      out_sum_d = raw_sum;
    end
`else
    out_sum_d = raw_sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_g_q      <= '0;
      s1_p_q      <= '0;
      s1_c0_q     <= 1'b0;
      s1_a_msb_q  <= 1'b0;
      s1_b_msb_q  <= 1'b0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_gg_q     <= '0;
      s2_pg_q     <= '0;
      s2_p_q      <= '0;
      s2_c0_q     <= 1'b0;
      s2_a_msb_q  <= 1'b0;
      s2_b_msb_q  <= 1'b0;
      s2_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= bus_io.in_valid;
        if (bus_io.in_valid) begin
          s1_g_q     <= s1_g_d;
          s1_p_q     <= s1_p_d;
          s1_c0_q    <= s1_c0_d;
          s1_a_msb_q <= bus_io.in_a[WIDTH-1];
          s1_b_msb_q <= s1_bx_d[WIDTH-1];
          s1_tag_q   <= bus_io.in_tag;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_gg_q    <= s2_gg_d;
          s2_pg_q    <= s2_pg_d;
          s2_p_q     <= s1_p_q;
          s2_c0_q    <= s1_c0_q;
          s2_a_msb_q <= s1_a_msb_q;
          s2_b_msb_q <= s1_b_msb_q;
          s2_tag_q   <= s1_tag_q;
        end
      end
      if (adv3) begin
        out_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          out_sum_q  <= out_sum_d;
          out_cout_q <= out_cout_d;
          out_ovf_q  <= out_ovf_d;
          out_tag_q  <= s2_tag_q;
        end
      end
    end
  end

  // Ends of the group-propagate vector are never consumed by the down-sweep.
  logic unused_pg;
  assign unused_pg = ^{s2_pg_q[0], s2_pg_q[WIDTH-1]};

endmodule
